ram_1port_rw_ctrl: RTL

- Traffic generator and checker that sits directly upstream of the single-port RAM IP (ram_1port) and drives its addr / wr_data / wr_en.
- On command it writes a deterministic pattern to every address, then reads every address back and compares the returned data against the expected pattern.
- Reports completion, pass count and error statistics to the board-level status logic (LEDs / debug probe).

---
 rtl/ram_1port_rw_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_1port_rw_ctrl.sv
// Write-then-verify traffic generator for a single-port RAM: fills every address
// with a seeded ramp pattern, reads it back through a latency-matched pipeline and reports errors.
module ram_1port_rw_ctrl #(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = 8,
   parameter int RD_LATENCY    = 1,
   parameter int ERR_CNT_WIDTH = 16,
   parameter bit LOOP_EN       = 1'b0
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     start,
   output logic [ADDR_WIDTH-1:0]    ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_wr_data,
   output logic                     ram_wr_en,
   input  logic [DATA_WIDTH-1:0]    ram_rd_data,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   output logic [ADDR_WIDTH-1:0]    first_err_addr,
   output logic [15:0]              pass_cnt
);

   localparam int DRAIN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    seed_q, seed_d;
   logic [DRAIN_W-1:0]       drain_q, drain_d;
   logic                     err_q, err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [ADDR_WIDTH-1:0]    first_err_addr_q, first_err_addr_d;
   logic [15:0]              pass_cnt_q, pass_cnt_d;

   // Compare pipeline: stage 0 holds the newest read, stage RD_LATENCY-1 lines up with ram_rd_data.
   logic                  pipe_vld_q  [RD_LATENCY];
   logic                  pipe_vld_d  [RD_LATENCY];
   logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];
   logic [ADDR_WIDTH-1:0] pipe_addr_d [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_exp_q  [RD_LATENCY];
   logic [DATA_WIDTH-1:0] pipe_exp_d  [RD_LATENCY];

   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] s);
      logic [ADDR_WIDTH+DATA_WIDTH-1:0] ext;
      ext = {{DATA_WIDTH{1'b0}}, a};
      return ext[DATA_WIDTH-1:0] + s;
   endfunction

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the case infers a latch.
      state_d          = state_q;
      addr_d           = addr_q;
      seed_d           = seed_q;
      drain_d          = drain_q;
      err_d            = err_q;
      err_cnt_d        = err_cnt_q;
      first_err_addr_d = first_err_addr_q;
      pass_cnt_d       = pass_cnt_q;

      pipe_vld_d[0]  = (state_q == S_READ);
      pipe_addr_d[0] = addr_q;
      pipe_exp_d[0]  = pattern(addr_q, seed_q);
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_addr_d[i] = pipe_addr_q[i-1];
         pipe_exp_d[i]  = pipe_exp_q[i-1];
      end

      if (pipe_vld_q[RD_LATENCY-1] && (ram_rd_data != pipe_exp_q[RD_LATENCY-1])) begin
         err_d = 1'b1;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
         if (!err_q) first_err_addr_d = pipe_addr_q[RD_LATENCY-1];
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d          = S_WRITE;
               addr_d           = '0;
               seed_d           = '0;
               err_d            = 1'b0;
               err_cnt_d        = '0;
               first_err_addr_d = '0;
            end
         end
         S_WRITE: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == '1) state_d = S_READ;
         end
         S_READ: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == '1) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end
         end
         S_DRAIN: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == DRAIN_W'(RD_LATENCY - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            pass_cnt_d = pass_cnt_q + 16'd1;
            seed_d     = seed_q + 1'b1;
            state_d    = (LOOP_EN && start) ? S_WRITE : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q          <= S_IDLE;
         addr_q           <= '0;
         seed_q           <= '0;
         drain_q          <= '0;
         err_q            <= 1'b0;
         err_cnt_q        <= '0;
         first_err_addr_q <= '0;
         pass_cnt_q       <= '0;
         // NOTE: the pipeline is reset because a stale valid bit after reset would raise a false error.
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_addr_q[i] <= '0;
            pipe_exp_q[i]  <= '0;
         end
      end else begin
         state_q          <= state_d;
         addr_q           <= addr_d;
         seed_q           <= seed_d;
         drain_q          <= drain_d;
         err_q            <= err_d;
         err_cnt_q        <= err_cnt_d;
         first_err_addr_q <= first_err_addr_d;
         pass_cnt_q       <= pass_cnt_d;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_d[i];
            pipe_addr_q[i] <= pipe_addr_d[i];
            pipe_exp_q[i]  <= pipe_exp_d[i];
         end
      end
   end

   assign ram_addr       = addr_q;
   assign ram_wr_en      = (state_q == S_WRITE);
   assign ram_wr_data    = (state_q == S_WRITE) ? pattern(addr_q, seed_q) : '0;
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_DONE);
   assign err            = err_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_addr_q;
   assign pass_cnt       = pass_cnt_q;

endmodule
